vector_store_unit: RTL and testbench

- Opposite end of the vector ALU datapath. Takes one 5-element vector result, already computed in parallel, and drains it to data memory as sequential 32-bit word writes.
- Element i goes to address base + 4*i, one element per accepted memory cycle.
- Sits between the vector result lanes and the data-memory write port. Signals completion to the control unit with a one-cycle done pulse.

---
 rtl/vec_pkg.sv | 15 +
 rtl/vec_lane_mux.sv | 19 +
 rtl/vector_store_unit.sv | 96 +++++++++
 tb/tb_vector_store_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared constants and state type for the vector store/load datapath.
package vec_pkg;

    localparam int unsigned NLANES     = 5;
    localparam int unsigned DW         = 32;
    localparam int unsigned AW         = 32;
    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        STORE,
        FIN
    } vst_state_t;

endpackage

// File: rtl/vec_lane_mux.sv
// Combinational NLANES:1 element selector over a packed vector.
module vec_lane_mux #(
    parameter int unsigned NLANES = 5,
    parameter int unsigned DW     = 32,
    parameter int unsigned IW     = 3
) (
    input  logic [NLANES*DW-1:0] vec,
    input  logic [IW-1:0]        sel,
    output logic [DW-1:0]        elem
);

    always_comb begin
        elem = '0;
        for (int unsigned i = 0; i < NLANES; i++) begin
            if (sel == IW'(i)) elem = vec[i*DW +: DW];
        end
    end

endmodule

// File: rtl/vector_store_unit.sv
// Drains one latched vector to memory as sequential word writes; Moore outputs.
module vector_store_unit
    import vec_pkg::*;
#(
    parameter int unsigned NLANES = vec_pkg::NLANES,
    parameter int unsigned DW     = vec_pkg::DW,
    parameter int unsigned AW     = vec_pkg::AW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [AW-1:0]        base_addr,
    input  logic [NLANES*DW-1:0] vec_in,
    input  logic [NLANES-1:0]    lane_mask,
    input  logic                 mem_ready,
    output logic                 busy,
    output logic                 MemWrite,
    output logic [AW-1:0]        DataAdr,
    output logic [DW-1:0]        WriteData,
    output logic                 done
);

    localparam int unsigned IW = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam int unsigned SH = $clog2(WORD_BYTES);

    vst_state_t          state, state_nx;
    logic [IW-1:0]       idx;
    logic [AW-1:0]       base_q;
    logic [NLANES*DW-1:0] vec_q;
    logic [NLANES-1:0]   mask_q;
    logic [DW-1:0]       elem;
    logic                lane_on;
    logic                advance;

    vec_lane_mux #(
        .NLANES(NLANES),
        .DW    (DW),
        .IW    (IW)
    ) u_mux (
        .vec (vec_q),
        .sel (idx),
        .elem(elem)
    );

    assign lane_on = mask_q[idx];
    // Masked lanes consume one cycle without waiting on the memory.
    assign advance = !lane_on || mem_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            idx    <= '0;
            base_q <= '0;
            vec_q  <= '0;
            mask_q <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    base_q <= base_addr;
                    vec_q  <= vec_in;
                    mask_q <= lane_mask;
                    idx    <= '0;
                end
                STORE: if (advance && idx != IW'(NLANES - 1)) idx <= idx + IW'(1);
                default: idx <= '0;
            endcase
        end
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nx = STORE;
            STORE: begin
                busy      = 1'b1;
                MemWrite  = lane_on;
                DataAdr   = base_q + (AW'(idx) << SH);
                WriteData = elem;
                if (advance && idx == IW'(NLANES - 1)) state_nx = FIN;
            end
            FIN: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_vector_store_unit.sv
// Directed cycle-by-cycle bench for vector_store_unit with hand-computed expectations.
module tb_vector_store_unit;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [31:0]  base_addr;
    logic [159:0] vec_in;
    logic [4:0]   lane_mask;
    logic         mem_ready;
    logic         busy;
    logic         MemWrite;
    logic [31:0]  DataAdr;
    logic [31:0]  WriteData;
    logic         done;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    localparam logic [159:0] VEC_A = {32'h55, 32'h44, 32'h33, 32'h22, 32'h11};
    localparam logic [159:0] VEC_B = {32'hE5, 32'hE4, 32'hE3, 32'hE2, 32'hE1};

    vector_store_unit #(.NLANES(5), .DW(32), .AW(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .base_addr(base_addr),
        .vec_in   (vec_in),
        .lane_mask(lane_mask),
        .mem_ready(mem_ready),
        .busy     (busy),
        .MemWrite (MemWrite),
        .DataAdr  (DataAdr),
        .WriteData(WriteData),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic eb, input logic emw,
                              input logic [31:0] ea, input logic [31:0] ed, input logic edn);
        check({tag, ".busy"},  {31'd0, busy},     {31'd0, eb});
        check({tag, ".mw"},    {31'd0, MemWrite}, {31'd0, emw});
        check({tag, ".adr"},   DataAdr,           ea);
        check({tag, ".wd"},    WriteData,         ed);
        check({tag, ".done"},  {31'd0, done},     {31'd0, edn});
    endtask

    // One clock cycle: drive inputs, check Moore outputs at the negedge, move to next cycle.
    task automatic cyc(input string tag, input logic st, input logic rdy, input logic eb,
                       input logic emw, input logic [31:0] ea, input logic [31:0] ed,
                       input logic edn);
        start     = st;
        mem_ready = rdy;
        @(negedge clk);
        check_outs(tag, eb, emw, ea, ed, edn);
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [31:0] b, input logic [159:0] v, input logic [4:0] m);
        base_addr = b;
        vec_in    = v;
        lane_mask = m;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = 32'hDEAD_BEEF;
        vec_in    = VEC_B;
        lane_mask = 5'b01010;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; base_addr = '0; vec_in = '0;
        lane_mask = '0; mem_ready = 1'b1;
        #12;
        check_outs("reset", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Full store, no stall
        launch(32'h100, VEC_A, 5'b11111);
        cyc("full.c1", 0, 1, 1, 1, 32'h100, 32'h11, 0);
        cyc("full.c2", 0, 1, 1, 1, 32'h104, 32'h22, 0);
        cyc("full.c3", 0, 1, 1, 1, 32'h108, 32'h33, 0);
        cyc("full.c4", 0, 1, 1, 1, 32'h10C, 32'h44, 0);
        cyc("full.c5", 0, 1, 1, 1, 32'h110, 32'h55, 0);
        cyc("full.c6", 0, 1, 1, 0, 32'h0,   32'h0,  1);
        cyc("full.c7", 0, 1, 0, 0, 32'h0,   32'h0,  0);

        // Stall on lane 1 for cycles 2-3
        launch(32'h100, VEC_A, 5'b11111);
        cyc("stall.c1", 0, 1, 1, 1, 32'h100, 32'h11, 0);
        cyc("stall.c2", 0, 0, 1, 1, 32'h104, 32'h22, 0);
        cyc("stall.c3", 0, 0, 1, 1, 32'h104, 32'h22, 0);
        cyc("stall.c4", 0, 1, 1, 1, 32'h104, 32'h22, 0);
        cyc("stall.c5", 0, 1, 1, 1, 32'h108, 32'h33, 0);
        cyc("stall.c6", 0, 1, 1, 1, 32'h10C, 32'h44, 0);
        cyc("stall.c7", 0, 1, 1, 1, 32'h110, 32'h55, 0);
        cyc("stall.c8", 0, 1, 1, 0, 32'h0,   32'h0,  1);

        // Sparse mask; masked lanes must not wait for mem_ready
        launch(32'h100, VEC_A, 5'b10101);
        cyc("mask.c1", 0, 1, 1, 1, 32'h100, 32'h11, 0);
        cyc("mask.c2", 0, 0, 1, 0, 32'h104, 32'h22, 0);
        cyc("mask.c3", 0, 1, 1, 1, 32'h108, 32'h33, 0);
        cyc("mask.c4", 0, 0, 1, 0, 32'h10C, 32'h44, 0);
        cyc("mask.c5", 0, 1, 1, 1, 32'h110, 32'h55, 0);
        cyc("mask.c6", 0, 1, 1, 0, 32'h0,   32'h0,  1);

        // Address wrap, then back-to-back all-zero mask launched from IDLE
        launch(32'hFFFF_FFF8, VEC_A, 5'b11111);
        cyc("wrap.c1", 0, 1, 1, 1, 32'hFFFF_FFF8, 32'h11, 0);
        cyc("wrap.c2", 0, 1, 1, 1, 32'hFFFF_FFFC, 32'h22, 0);
        cyc("wrap.c3", 0, 1, 1, 1, 32'h0,         32'h33, 0);
        cyc("wrap.c4", 0, 1, 1, 1, 32'h4,         32'h44, 0);
        cyc("wrap.c5", 0, 1, 1, 1, 32'h8,         32'h55, 0);
        cyc("wrap.c6", 0, 1, 1, 0, 32'h0,         32'h0,  1);
        launch(32'h200, VEC_A, 5'b00000);
        cyc("zero.c1", 0, 0, 1, 0, 32'h200, 32'h11, 0);
        cyc("zero.c2", 0, 0, 1, 0, 32'h204, 32'h22, 0);
        cyc("zero.c3", 0, 0, 1, 0, 32'h208, 32'h33, 0);
        cyc("zero.c4", 0, 0, 1, 0, 32'h20C, 32'h44, 0);
        cyc("zero.c5", 0, 0, 1, 0, 32'h210, 32'h55, 0);
        cyc("zero.c6", 0, 0, 1, 0, 32'h0,   32'h0,  1);

        // start while busy is ignored and not queued
        launch(32'h100, VEC_A, 5'b11111);
        cyc("ign.c1", 0, 1, 1, 1, 32'h100, 32'h11, 0);
        cyc("ign.c2", 0, 1, 1, 1, 32'h104, 32'h22, 0);
        base_addr = 32'h300; vec_in = VEC_B; lane_mask = 5'b11111;
        cyc("ign.c3", 1, 1, 1, 1, 32'h108, 32'h33, 0);
        cyc("ign.c4", 0, 1, 1, 1, 32'h10C, 32'h44, 0);
        cyc("ign.c5", 0, 1, 1, 1, 32'h110, 32'h55, 0);
        cyc("ign.c6", 0, 1, 1, 0, 32'h0,   32'h0,  1);
        cyc("ign.c7", 0, 1, 0, 0, 32'h0,   32'h0,  0);
        cyc("ign.c8", 0, 1, 0, 0, 32'h0,   32'h0,  0);

        // Mid-store asynchronous reset
        launch(32'h100, VEC_A, 5'b11111);
        cyc("rst.c1", 0, 1, 1, 1, 32'h100, 32'h11, 0);
        cyc("rst.c2", 0, 1, 1, 1, 32'h104, 32'h22, 0);
        reset = 1'b0;
        #1;
        check_outs("rst.async", 0, 0, 32'h0, 32'h0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        cyc("rst.c4", 0, 1, 0, 0, 32'h0, 32'h0, 0);
        cyc("rst.c5", 0, 1, 0, 0, 32'h0, 32'h0, 0);
        cyc("rst.c6", 0, 1, 0, 0, 32'h0, 32'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
